regression_mac_seq: RTL and testbench

//   Sequential multi-feature linear regression evaluator: y = c0 + cin + sum_{i=0..N_FEAT-1} c_i*f_i.

---
 rtl/regression_pkg.sv | 38 +++
 rtl/regression_mul.sv | 13 +
 rtl/regression_mac_seq.sv | 130 +++++++++++++
 tb/tb_regression_mac_seq.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regression_pkg.sv
// Shared types, default widths and the carry-aware adder for the regression evaluator.
// Saturation itself is selected in the top by the REGRESSION_SAT_EN macro.
package regression_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_F_W    = 16;
    localparam int DEF_C_W    = 16;
    localparam int DEF_ACC_W  = 32;
    localparam int DEF_N_FEAT = 4;
    localparam int MAX_W      = 64;

    typedef struct packed {
        logic             carry;
        logic [MAX_W-1:0] sum;
    } add_res_t;

    // Adds two operands, reports any bit landing at or above position w, optionally clamps to all-ones.
    function automatic add_res_t sat_add(input logic [MAX_W-1:0] a, input logic [MAX_W-1:0] b,
                                         input int unsigned w, input logic sat);
        add_res_t       r;
        logic [MAX_W:0] full;
        logic [MAX_W:0] mask;
        full    = {1'b0, a} + {1'b0, b};
        mask    = ({{MAX_W{1'b0}}, 1'b1} << w) - {{MAX_W{1'b0}}, 1'b1};
        r.carry = |(full & ~mask);
        r.sum   = full[MAX_W-1:0] & mask[MAX_W-1:0];
        if (sat && r.carry) begin
            r.sum = mask[MAX_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/regression_mul.sv
// Unsigned F_W x C_W multiplier with no internal registers, kept separate so it can be pipelined later.
module regression_mul #(
    parameter int F_W = 16,
    parameter int C_W = 16
) (
    input  logic [F_W-1:0]     f,
    input  logic [C_W-1:0]     c,
    output logic [F_W+C_W-1:0] p
);

    assign p = (F_W + C_W)'(f) * (F_W + C_W)'(c);

endmodule

// File: rtl/regression_mac_seq.sv
// Sequential linear regression evaluator y = c0 + cin + sum(c_i*f_i) over one shared multiplier.
// Define REGRESSION_SAT_EN to saturate the accumulator at all-ones once overflow occurs.
module regression_mac_seq
    import regression_pkg::*;
#(
    parameter int F_W    = DEF_F_W,
    parameter int C_W    = DEF_C_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int N_FEAT = DEF_N_FEAT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [ACC_W-1:0] c0,
    input  logic             cin,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [F_W-1:0]   f_in,
    input  logic [C_W-1:0]   c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] y,
    output logic             ovf
);

    localparam int CNT_W = $clog2(N_FEAT + 1);
    localparam int P_W   = F_W + C_W;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_FEAT - 1);
`ifdef REGRESSION_SAT_EN
    localparam logic SAT_EN = 1'b1;
`else
    localparam logic SAT_EN = 1'b0;
`endif

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] y_r;
    logic             ovf_r;
    logic             out_vld;
    logic [P_W-1:0]   prod;
    logic [ACC_W:0]   step_bias;
    logic [ACC_W:0]   step_pair;

    // Returns {ovf, next_acc}; under saturation a previously flagged overflow pins the sum at all-ones.
    function automatic logic [ACC_W:0] acc_step(input logic [ACC_W-1:0] a, input logic [MAX_W-1:0] b,
                                               input logic sticky);
        add_res_t r;
        r = sat_add(MAX_W'(a), b, ACC_W, SAT_EN);
        if (SAT_EN && sticky) begin
            r.sum = MAX_W'({ACC_W{1'b1}});
        end
        return {r.carry | sticky, r.sum[ACC_W-1:0]};
    endfunction

    regression_mul #(.F_W(F_W), .C_W(C_W)) u_mul (
        .f (f_in),
        .c (c_in),
        .p (prod)
    );

    assign step_bias = acc_step(c0, MAX_W'(cin), 1'b0);
    assign step_pair = acc_step(acc, MAX_W'(prod), ovf_r);

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = ACC;
            end
            ACC: begin
                in_ready = 1'b1;
                if (in_valid && cnt == LAST) state_nxt = DONE;
            end
            DONE: begin
                if (out_vld && out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            acc     <= '0;
            ovf_r   <= 1'b0;
            out_vld <= 1'b0;
            y_r     <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        acc   <= step_bias[ACC_W-1:0];
                        ovf_r <= step_bias[ACC_W];
                        cnt   <= '0;
                    end
                end
                ACC: begin
                    if (in_valid) begin
                        acc   <= step_pair[ACC_W-1:0];
                        ovf_r <= step_pair[ACC_W];
                        cnt   <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    // First DONE cycle loads the output register; it then holds until the handshake.
                    if (!out_vld) begin
                        out_vld <= 1'b1;
                        y_r     <= acc;
                    end else if (out_ready) begin
                        out_vld <= 1'b0;
                        ovf_r   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_valid = out_vld;
    assign y         = y_r;
    assign ovf       = ovf_r;

endmodule

// File: tb/tb_regression_mac_seq.sv
// Scoreboard bench for regression_mac_seq: one N_FEAT=1 instance and one N_FEAT=4 instance.
module tb_regression_mac_seq;

    typedef struct {
        logic [31:0] y;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;

    logic        start_a, cin_a, in_valid_a, out_ready_a;
    logic [31:0] c0_a;
    logic [15:0] f_a, c_a;
    logic        busy_a, in_ready_a, out_valid_a, ovf_a;
    logic [31:0] y_a;

    logic        start_b, cin_b, in_valid_b, out_ready_b;
    logic [31:0] c0_b;
    logic [15:0] f_b, c_b;
    logic        busy_b, in_ready_b, out_valid_b, ovf_b;
    logic [31:0] y_b;

    exp_t q_a[$];
    exp_t q_b[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    regression_mac_seq #(.F_W(16), .C_W(16), .ACC_W(32), .N_FEAT(1)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .c0(c0_a), .cin(cin_a), .busy(busy_a),
        .in_valid(in_valid_a), .in_ready(in_ready_a), .f_in(f_a), .c_in(c_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a), .y(y_a), .ovf(ovf_a)
    );

    regression_mac_seq #(.F_W(16), .C_W(16), .ACC_W(32), .N_FEAT(4)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .c0(c0_b), .cin(cin_b), .busy(busy_b),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .f_in(f_b), .c_in(c_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .y(y_b), .ovf(ovf_b)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitors pop the scoreboard whenever a result handshake is about to complete.
    always @(negedge clk) begin
        if (!rst && out_valid_a && out_ready_a) begin
            if (q_a.size() == 0) begin
                chk("mon_a_unexpected_result", 64'(y_a), 64'hDEAD_0000_0000);
            end else begin
                exp_t e;
                e = q_a.pop_front();
                chk("mon_a_y", 64'(y_a), 64'(e.y));
                chk("mon_a_ovf", 64'(ovf_a), 64'(e.ovf));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && out_valid_b && out_ready_b) begin
            if (q_b.size() == 0) begin
                chk("mon_b_unexpected_result", 64'(y_b), 64'hDEAD_0000_0000);
            end else begin
                exp_t e;
                e = q_b.pop_front();
                chk("mon_b_y", 64'(y_b), 64'(e.y));
                chk("mon_b_ovf", 64'(ovf_b), 64'(e.ovf));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_b(input logic [31:0] yv, input logic ov);
        exp_t e;
        e.y   = yv;
        e.ovf = ov;
        q_b.push_back(e);
    endtask

    task automatic go_b(input logic [31:0] c0v, input logic cinv);
        start_b = 1'b1;
        c0_b    = c0v;
        cin_b   = cinv;
        tick();
        start_b = 1'b0;
    endtask

    task automatic feed_b(input logic [15:0] fv, input logic [15:0] cv, input int gaps);
        in_valid_b = 1'b0;
        repeat (gaps) tick();
        in_valid_b = 1'b1;
        f_b        = fv;
        c_b        = cv;
        tick();
        in_valid_b = 1'b0;
    endtask

    task automatic wait_idle_b(input string name);
        int k;
        k = 0;
        while (busy_b && k < 20) begin
            tick();
            k++;
        end
        chk(name, 64'(busy_b), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t ea;
        logic [31:0] t4_y;
        rst = 1'b1;
        start_a = 0; cin_a = 0; in_valid_a = 0; out_ready_a = 1; c0_a = 0; f_a = 0; c_a = 0;
        start_b = 0; cin_b = 0; in_valid_b = 0; out_ready_b = 1; c0_b = 0; f_b = 0; c_b = 0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_busy", 64'(busy_b), 0);
        chk("rst_in_ready", 64'(in_ready_b), 0);
        chk("rst_out_valid", 64'(out_valid_b), 0);
        chk("rst_ovf", 64'(ovf_b), 0);
        chk("rst_y", 64'(y_b), 0);
        chk("rst_a_out_valid", 64'(out_valid_a), 0);

        // T1: single term, result visible on cycle 3 after start
        ea.y = 32'd510000; ea.ovf = 1'b0;
        q_a.push_back(ea);
        start_a = 1'b1; c0_a = 32'd10000; cin_a = 1'b0;
        in_valid_a = 1'b1; f_a = 16'd5000; c_a = 16'd100;
        tick();
        start_a = 1'b0;
        chk("t1_ready_in_acc", 64'(in_ready_a), 1);
        chk("t1_valid_cycle1", 64'(out_valid_a), 0);
        tick();
        in_valid_a = 1'b0;
        chk("t1_valid_cycle2", 64'(out_valid_a), 0);
        tick();
        chk("t1_valid_cycle3", 64'(out_valid_a), 1);
        tick();
        chk("t1_idle_after_hs", 64'(busy_a), 0);

        // T2: four back-to-back pairs
        push_b(32'd108, 1'b0);
        go_b(32'd7, 1'b1);
        chk("t2_busy", 64'(busy_b), 1);
        chk("t2_in_ready_acc", 64'(in_ready_b), 1);
        feed_b(16'd1, 16'd2, 0);
        feed_b(16'd3, 16'd4, 0);
        feed_b(16'd5, 16'd6, 0);
        feed_b(16'd7, 16'd8, 0);
        chk("t2_in_ready_after_last", 64'(in_ready_b), 0);
        wait_idle_b("t2_done_timeout");

        // T3: gapped input and stalled consumer
        push_b(32'd108, 1'b0);
        out_ready_b = 1'b0;
        go_b(32'd7, 1'b1);
        feed_b(16'd1, 16'd2, 1);
        feed_b(16'd3, 16'd4, 2);
        feed_b(16'd5, 16'd6, 1);
        feed_b(16'd7, 16'd8, 2);
        begin
            int k;
            k = 0;
            while (!out_valid_b && k < 10) begin
                tick();
                k++;
            end
        end
        chk("t3_out_valid_timeout", 64'(out_valid_b), 1);
        for (int i = 0; i < 5; i++) begin
            chk("t3_stall_y", 64'(y_b), 64'd108);
            chk("t3_stall_valid", 64'(out_valid_b), 1);
            tick();
        end
        out_ready_b = 1'b1;
        wait_idle_b("t3_done_timeout");

        // T4: overflow beyond 32 bits
`ifdef REGRESSION_SAT_EN
        t4_y = 32'hFFFF_FFFF;
`else
        t4_y = 32'h0000_0010;
`endif
        push_b(t4_y, 1'b1);
        go_b(32'hFFFF_FFF0, 1'b0);
        feed_b(16'd1, 16'd32, 0);
        chk("t4_ovf_early", 64'(ovf_b), 1);
        feed_b(16'd0, 16'd0, 0);
        feed_b(16'd0, 16'd0, 0);
        feed_b(16'd0, 16'd0, 0);
        wait_idle_b("t4_done_timeout");
        chk("t4_ovf_cleared", 64'(ovf_b), 0);

        // T5: start pulses while busy are ignored; restart right after the handshake
        push_b(32'd108, 1'b0);
        out_ready_b = 1'b0;
        go_b(32'd7, 1'b1);
        feed_b(16'd1, 16'd2, 0);
        start_b = 1'b1; c0_b = 32'd999;
        feed_b(16'd3, 16'd4, 0);
        start_b = 1'b0; c0_b = 32'd7;
        feed_b(16'd5, 16'd6, 0);
        feed_b(16'd7, 16'd8, 0);
        start_b = 1'b1; c0_b = 32'd555;
        tick();
        start_b = 1'b0;
        tick();
        chk("t5_busy_in_done", 64'(busy_b), 1);
        chk("t5_y_unchanged", 64'(y_b), 64'd108);
        out_ready_b = 1'b1;
        tick();
        chk("t5_idle_after_hs", 64'(busy_b), 0);
        push_b(32'd104, 1'b0);
        go_b(32'd100, 1'b0);
        chk("t5_restart_accepted", 64'(busy_b), 1);
        for (int i = 0; i < 4; i++) feed_b(16'd1, 16'd1, 0);
        wait_idle_b("t5_done_timeout");

        // T6: reset in the middle of an evaluation
        go_b(32'd50, 1'b1);
        feed_b(16'd9, 16'd9, 0);
        feed_b(16'd9, 16'd9, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_busy", 64'(busy_b), 0);
        chk("t6_in_ready", 64'(in_ready_b), 0);
        chk("t6_out_valid", 64'(out_valid_b), 0);
        chk("t6_ovf", 64'(ovf_b), 0);
        chk("t6_y", 64'(y_b), 0);
        push_b(32'd108, 1'b0);
        go_b(32'd7, 1'b1);
        feed_b(16'd1, 16'd2, 0);
        feed_b(16'd3, 16'd4, 0);
        feed_b(16'd5, 16'd6, 0);
        feed_b(16'd7, 16'd8, 0);
        wait_idle_b("t6_done_timeout");

        tick();
        chk("drain_a", 64'(q_a.size()), 0);
        chk("drain_b", 64'(q_b.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
